// File: rtl/calc_seq_pkg.sv
`default_nettype none
// ==================================================================
// calc_seq_pkg: opcodes, ALU control codes, FIFO depth and field map
// Rev 1.0 - initial release
// ==================================================================
package calc_seq_pkg;

   localparam int c_instr_w    = 16;
   localparam int c_fifo_depth = 4;

   localparam int c_op_lsb   = 14;
   localparam int c_rw_lsb   = 11;
   localparam int c_rx_lsb   = 8;
   localparam int c_ry_lsb   = 5;
   localparam int c_ctrl_lsb = 1;
   localparam int c_imm_lsb  = 0;

   localparam int c_op_w   = 2;
   localparam int c_reg_w  = 3;
   localparam int c_ctrl_w = 4;
   localparam int c_imm_w  = 8;

   typedef enum logic [1:0] {
      OP_LDI  = 2'b00,
      OP_ALU  = 2'b01,
      OP_NOP  = 2'b10,
      OP_ITER = 2'b11
   } op_e;

   localparam logic [3:0] c_ctrl_pass_x = 4'h0;
   localparam logic [3:0] c_ctrl_add    = 4'h1;
   localparam logic [3:0] c_ctrl_sub    = 4'h2;
   localparam logic [3:0] c_ctrl_and    = 4'h3;
   localparam logic [3:0] c_ctrl_or     = 4'h4;
   localparam logic [3:0] c_ctrl_xor    = 4'h5;

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_exec = 1'b1;

   typedef struct packed {
      op_e                 op;
      logic [c_reg_w-1:0]  rw;
      logic [c_reg_w-1:0]  rx;
      logic [c_reg_w-1:0]  ry;
      logic [c_ctrl_w-1:0] ctrl;
   } dec_t;

   function automatic dec_t f_decode(input logic [c_instr_w-1:0] w);
      dec_t d;
      d.op   = op_e'(w[c_op_lsb +: c_op_w]);
      d.rw   = w[c_rw_lsb +: c_reg_w];
      d.rx   = w[c_rx_lsb +: c_reg_w];
      d.ry   = w[c_ry_lsb +: c_reg_w];
      d.ctrl = w[c_ctrl_lsb +: c_ctrl_w];
      return d;
   endfunction

   function automatic logic [c_imm_w-1:0] f_imm(input logic [c_instr_w-1:0] w);
      return w[c_imm_lsb +: c_imm_w];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_fifo.sv
`default_nettype none
// ==================================================================
// seq_fifo: parameterised FIFO, registered storage, async reset
// Rev 1.0 - initial release
// ==================================================================
module seq_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cw = $clog2(DEPTH + 1);

   localparam logic [c_aw-1:0] c_last_ptr = c_aw'(DEPTH - 1);
   localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
   localparam logic [c_cw-1:0] c_full_cnt = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == c_full_cnt);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage carries no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ==================================================================
// calc_sequencer: queues instructions and sequences them into a calculator
// Rev 1.0 - initial release
// ==================================================================
module calc_sequencer
   import calc_seq_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic        WEN,
   output logic [2:0]  RW,
   output logic [2:0]  RX,
   output logic [2:0]  RY,
   output logic [7:0]  DataIn,
   output logic        Sel,
   output logic [3:0]  Ctrl,
   input  logic        Carry,
   output logic        busy,
   output logic        done,
   output logic        carry_flag
);

   logic [c_instr_w-1:0] w_fifo_data;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic [c_instr_w-1:0] r_cur;
   logic [2:0]           r_cnt;
   logic                 r_done;
   logic                 r_carry;
   logic                 w_exec;
   logic                 w_last;
   dec_t                 w_cur;
   op_e                  w_head_op;
   logic [2:0]           w_head_cnt;

   assign w_cur      = f_decode(r_cur);
   assign w_head_op  = op_e'(w_fifo_data[c_op_lsb +: c_op_w]);
   assign w_head_cnt = w_fifo_data[c_rx_lsb +: c_reg_w];

   assign w_exec = (r_state == c_st_exec);
   assign w_last = w_exec && (r_cnt == 3'd0);
   // Refill from the queue whenever nothing is executing or the current op ends.
   assign w_pop  = !w_empty && (!w_exec || w_last);
   assign w_push = instr_valid && !w_full;

   assign instr_ready = !w_full;
   assign busy        = !w_empty || w_exec;
   assign done        = r_done;
   assign carry_flag  = r_carry;

   seq_fifo #(
      .WIDTH (c_instr_w),
      .DEPTH (c_fifo_depth)
   ) u_fifo (
      .clk     (Clk),
      .rst     (Rst),
      .i_push  (w_push),
      .i_data  (instr),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (!w_empty) w_state_nxt = c_st_exec;
         c_st_exec: if (w_last && w_empty) w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   // The counter holds the number of EXEC cycles still to follow the current one.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cur <= '0;
         r_cnt <= 3'd0;
      end else if (w_pop) begin
         r_cur <= w_fifo_data;
         r_cnt <= (w_head_op == OP_ITER) ? w_head_cnt : 3'd0;
      end else if (w_exec && !w_last) begin
         r_cnt <= r_cnt - 3'd1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_done  <= 1'b0;
         r_carry <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_last && (w_cur.op == OP_ALU || w_cur.op == OP_ITER)) begin
            r_carry <= Carry;
         end
      end
   end

   always_comb begin
      WEN    = 1'b0;
      RW     = 3'd0;
      RX     = 3'd0;
      RY     = 3'd0;
      DataIn = 8'd0;
      Sel    = 1'b0;
      Ctrl   = 4'd0;
      if (w_exec) begin
         case (w_cur.op)
            OP_LDI: begin
               WEN    = 1'b1;
               RW     = w_cur.rw;
               DataIn = f_imm(r_cur);
               Ctrl   = c_ctrl_pass_x;
            end
            OP_ALU: begin
               WEN  = 1'b1;
               RW   = w_cur.rw;
               RX   = w_cur.rx;
               RY   = w_cur.ry;
               Sel  = 1'b1;
               Ctrl = w_cur.ctrl;
            end
            OP_ITER: begin
               WEN  = 1'b1;
               RW   = w_cur.rw;
               RX   = w_cur.rw;
               RY   = w_cur.ry;
               Sel  = 1'b1;
               Ctrl = w_cur.ctrl;
            end
            default: begin
               WEN = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ==================================================================
// tb_calc_sequencer: directed vectors with scoreboard against a calculator model
// Rev 1.0 - initial release
// ==================================================================
module tb_calc_sequencer;
   import calc_seq_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        WEN;
   logic [2:0]  RW;
   logic [2:0]  RX;
   logic [2:0]  RY;
   logic [7:0]  DataIn;
   logic        Sel;
   logic [3:0]  Ctrl;
   logic        Carry;
   logic        busy;
   logic        done;
   logic        carry_flag;

   always #5 Clk = ~Clk;

   calc_sequencer dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .WEN         (WEN),
      .RW          (RW),
      .RX          (RX),
      .RY          (RY),
      .DataIn      (DataIn),
      .Sel         (Sel),
      .Ctrl        (Ctrl),
      .Carry       (Carry),
      .busy        (busy),
      .done        (done),
      .carry_flag  (carry_flag)
   );

   // Register-file calculator: X = Sel ? R[RX] : DataIn, Y = R[RY]
   logic [7:0] regs [8] = '{default: 8'h00};
   logic [7:0] alu_x, alu_y, alu_res;
   logic       alu_c;

   always_comb begin
      alu_x = Sel ? regs[RX] : DataIn;
      alu_y = regs[RY];
      {alu_c, alu_res} = 9'h000;
      case (Ctrl)
         c_ctrl_pass_x: {alu_c, alu_res} = {1'b0, alu_x};
         c_ctrl_add:    {alu_c, alu_res} = {1'b0, alu_x} + {1'b0, alu_y};
         c_ctrl_sub:    {alu_c, alu_res} = {1'b0, alu_x} - {1'b0, alu_y};
         c_ctrl_and:    {alu_c, alu_res} = {1'b0, alu_x & alu_y};
         c_ctrl_or:     {alu_c, alu_res} = {1'b0, alu_x | alu_y};
         c_ctrl_xor:    {alu_c, alu_res} = {1'b0, alu_x ^ alu_y};
         default:       {alu_c, alu_res} = 9'h000;
      endcase
   end
   assign Carry = alu_c;

   always @(posedge Clk) begin
      if (WEN) regs[RW] <= alu_res;
   end

   typedef struct {
      logic [1:0] op;
      int         wen;
      logic [2:0] rw;
      logic [7:0] val;
      logic       cf;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   wen_cnt = 0;
   int   wen_seen = 0;
   int   cyc = 0;
   int   last_done_cyc = -10;
   int   streak = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] op, input int wen, input logic [2:0] rw,
                               input logic [7:0] val, input logic cf);
      exp_t e;
      e.op = op; e.wen = wen; e.rw = rw; e.val = val; e.cf = cf;
      return e;
   endfunction

   function automatic logic [15:0] f_ldi(input logic [2:0] rw, input logic [7:0] imm);
      return {2'b00, rw, 3'b000, imm};
   endfunction

   function automatic logic [15:0] f_alu(input logic [3:0] ctrl, input logic [2:0] rw,
                                         input logic [2:0] rx, input logic [2:0] ry);
      return {2'b01, rw, rx, ry, ctrl, 1'b0};
   endfunction

   function automatic logic [15:0] f_iter(input logic [3:0] ctrl, input logic [2:0] rw,
                                          input logic [2:0] cnt, input logic [2:0] ry);
      return {2'b11, rw, cnt, ry, ctrl, 1'b0};
   endfunction

   localparam logic [15:0] c_nop = 16'h8000;

   // Monitor: each done retires the oldest expected instruction.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         cyc++;
         if (Rst) begin
            wen_cnt = 0;
         end else begin
            if (done) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_unexpected_done: got done=1, expected no pending instruction");
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_wen_cycles", wen_cnt, e.wen);
                  if (e.op != OP_NOP) chk("sb_dest_reg", regs[e.rw], e.val);
                  chk("sb_carry_flag", carry_flag, e.cf);
               end
               streak = (last_done_cyc == cyc - 1) ? streak + 1 : 1;
               last_done_cyc = cyc;
               wen_cnt = 0;
            end
            if (WEN) wen_cnt++;
         end
      end
   end

   always @(posedge Clk) begin
      #1;
      if (WEN && !Rst) wen_seen++;
   end

   task automatic push(input logic [15:0] w, input exp_t e);
      int n = 0;
      @(negedge Clk);
      instr_valid = 1'b0;
      while (!instr_ready && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (!instr_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout: instr_ready=0 after 100 cycles, expected 1");
      end else begin
         instr       = w;
         instr_valid = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic release_bus();
      @(negedge Clk);
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL %s: busy=1 after 200 cycles, expected 0", name);
      end
      @(negedge Clk);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_wen"},    WEN, 0);
      chk({tag, "_rw"},     RW, 0);
      chk({tag, "_rx"},     RX, 0);
      chk({tag, "_ry"},     RY, 0);
      chk({tag, "_datain"}, DataIn, 0);
      chk({tag, "_sel"},    Sel, 0);
      chk({tag, "_ctrl"},   Ctrl, 0);
      chk({tag, "_done"},   done, 0);
      chk({tag, "_cflag"},  carry_flag, 0);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_ready"},  instr_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc, low, hi, g, base;
      Rst         = 1'b1;
      instr       = 16'h0000;
      instr_valid = 1'b0;
      repeat (2) @(negedge Clk);
      chk_quiet("reset");
      Rst = 1'b0;

      // LDI r1,05: no bypass, one write cycle, done next, busy falls
      push(f_ldi(3'd1, 8'h05), mk(OP_LDI, 1, 3'd1, 8'h05, 1'b0));
      release_bus();
      chk("ldi_queued_wen", WEN, 0);
      chk("ldi_queued_busy", busy, 1);
      @(negedge Clk);
      chk("ldi_wen", WEN, 1);
      chk("ldi_rw", RW, 1);
      chk("ldi_sel", Sel, 0);
      chk("ldi_datain", DataIn, 8'h05);
      chk("ldi_ctrl", Ctrl, c_ctrl_pass_x);
      @(negedge Clk);
      chk("ldi_done", done, 1);
      chk("ldi_wen_after", WEN, 0);
      chk("ldi_busy_after", busy, 0);
      wait_idle("ldi_idle");

      // F0 + 20 = 110: r3 = 10, carry set, three back-to-back dones
      push(f_ldi(3'd1, 8'hF0), mk(OP_LDI, 1, 3'd1, 8'hF0, 1'b0));
      push(f_ldi(3'd2, 8'h20), mk(OP_LDI, 1, 3'd2, 8'h20, 1'b0));
      push(f_alu(c_ctrl_add, 3'd3, 3'd1, 3'd2), mk(OP_ALU, 1, 3'd3, 8'h10, 1'b1));
      release_bus();
      wait_idle("alu_chain_idle");
      chk("alu_chain_done_streak", streak, 3);

      // r4 = 1 doubled four times = 10, last add has no carry
      push(f_ldi(3'd4, 8'h01), mk(OP_LDI, 1, 3'd4, 8'h01, 1'b1));
      push(f_iter(c_ctrl_add, 3'd4, 3'd3, 3'd4), mk(OP_ITER, 4, 3'd4, 8'h10, 1'b0));
      release_bus();
      wait_idle("iter_idle");

      // NOP between ALU ops keeps the carry of the first ALU
      push(f_alu(c_ctrl_add, 3'd5, 3'd1, 3'd2), mk(OP_ALU, 1, 3'd5, 8'h10, 1'b1));
      push(c_nop, mk(OP_NOP, 0, 3'd0, 8'h00, 1'b1));
      push(f_alu(c_ctrl_and, 3'd6, 3'd1, 3'd2), mk(OP_ALU, 1, 3'd6, 8'h20, 1'b0));
      release_bus();
      wait_idle("nop_idle");
      chk("nop_done_streak", streak, 3);

      // Long ITER stalls the queue while instr_valid is held
      push(f_iter(c_ctrl_xor, 3'd0, 3'd7, 3'd0), mk(OP_ITER, 8, 3'd0, 8'h00, 1'b0));
      release_bus();
      g = 0;
      while (!WEN && g < 20) begin
         @(negedge Clk);
         g++;
      end
      chk("fill_iter_started", WEN, 1);
      acc = 0; low = 0; hi = 0;
      instr       = c_nop;
      instr_valid = 1'b1;
      for (int k = 0; k < 40 && hi < 6; k++) begin
         if (instr_ready) begin
            if (low == 0) acc++;
            else hi++;
            exp_q.push_back(mk(OP_NOP, 0, 3'd0, 8'h00, 1'b0));
         end else begin
            low++;
         end
         @(negedge Clk);
      end
      instr_valid = 1'b0;
      chk("fill_accepts", acc, 4);
      chk("fill_ready_low_cycles", low, 4);
      chk("fill_steady_pushes", hi, 6);
      wait_idle("fill_idle");
      chk("sb_drained", exp_q.size(), 0);

      // Reset during the third ITER cycle
      base = wen_seen;
      push(f_alu(c_ctrl_add, 3'd3, 3'd1, 3'd2), mk(OP_ALU, 1, 3'd3, 8'h10, 1'b1));
      push(f_iter(c_ctrl_add, 3'd3, 3'd7, 3'd3), mk(OP_ITER, 8, 3'd3, 8'h00, 1'b0));
      push(c_nop, mk(OP_NOP, 0, 3'd0, 8'h00, 1'b0));
      push(c_nop, mk(OP_NOP, 0, 3'd0, 8'h00, 1'b0));
      release_bus();
      g = 0;
      while (wen_seen < base + 4 && g < 40) begin
         @(posedge Clk);
         #2;
         g++;
      end
      chk("rst_at_iter_cycle3", wen_seen - base, 4);
      chk("rst_pre_cflag", carry_flag, 1);
      Rst = 1'b1;
      #1;
      exp_q.delete();
      chk_quiet("rst_mid_iter");
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      repeat (12) @(negedge Clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cflag", carry_flag, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
